// File: rtl/imem_loader_ctrl.sv
// Instruction-memory boot/reload sequencer.
// Accepts 32-bit words over a valid/ready stream and writes each word into the
// CPU load port as four big-endian byte writes. The CPU is held off (pc_enable=0)
// until every word is written.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | nothing loaded or load aborted; waiting for a valid start
// S_WAIT     | load in progress, ready for the next instruction word
// S_WRITE    | emitting the four byte writes of the latched word
// S_DRAIN    | one settle cycle after the final write, before fetch begins
// S_RUN      | program committed, CPU running; a new start reloads
module imem_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          LEN_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_words,
  input  logic             abort,
  input  logic             word_valid,
  input  logic [31:0]      word_data,
  output logic             word_ready,
  output logic             We,
  output logic [31:0]      write_address,
  output logic [7:0]       write_data,
  output logic             pc_enable,
  output logic             pipe_flush,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] word_idx_nxt;
  logic [1:0]       byte_idx;
  logic [31:0]      word_q;
  logic             done_q;
  logic             error_q;
  logic             loading;
  logic             len_ok;
  logic [7:0]       byte_sel;

  assign loading      = (state == S_WAIT) || (state == S_WRITE) || (state == S_DRAIN);
  assign len_ok       = (num_words != '0) && (num_words <= MAX_LEN);
  assign word_idx_nxt = word_idx + LEN_W'(1);

  // Sequencer state, counters and the one-cycle done/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (loading && abort) begin
        // Abandon mid-word; bytes already written stay in memory.
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_RUN: begin
            if (start) begin
              if (len_ok) begin
                len_q    <= num_words;
                word_idx <= '0;
                state    <= S_WAIT;
              end else begin
                error_q <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (word_valid) begin
              word_q   <= word_data;
              byte_idx <= 2'd0;
              state    <= S_WRITE;
            end
          end
          S_WRITE: begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_idx <= word_idx_nxt;
              state    <= (word_idx_nxt == len_q) ? S_DRAIN : S_WAIT;
            end
          end
          S_DRAIN: begin
            state  <= S_RUN;
            done_q <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Big-endian byte select: byte 0 carries the most significant byte
  always_comb begin
    byte_sel = 8'h00;
    case (byte_idx)
      2'd0:    byte_sel = word_q[31:24];
      2'd1:    byte_sel = word_q[23:16];
      2'd2:    byte_sel = word_q[15:8];
      default: byte_sel = word_q[7:0];
    endcase
  end

  // Load-port and status outputs decoded from state; bus is zero when idle
  always_comb begin
    word_ready    = (state == S_WAIT);
    We            = (state == S_WRITE);
    write_address = 32'h0;
    write_data    = 8'h00;
    if (state == S_WRITE) begin
      write_address = BASE_ADDR + (32'(word_idx) << 2) + 32'(byte_idx);
      write_data    = byte_sel;
    end
    pc_enable  = (state == S_RUN);
    pipe_flush = loading;
    busy       = loading;
    done       = done_q;
    error      = error_q;
  end

endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
Boot/reload sequencer for the pipelined CPU's instruction memory. Accepts 32-bit instruction words over a valid/ready stream and serialises each into four byte writes on the CPU's We/write_address/write_data load port. Holds pc_enable low throughout loading and releases it once the program is committed. Sits between the host/testbench program source and the processor top level.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction word.
MAX_WORDS, 256, largest accepted program length in words.
LEN_W, 9, width of num_words; must satisfy 2^LEN_W > MAX_WORDS.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  single-cycle pulse; begins a load of num_words words.
num_words  input  LEN_W  program length in words; sampled only on an accepted start.
abort  input  1  cancels a load in progress.
word_valid  input  1  word_data holds a valid instruction word.
word_data  input  32  instruction word.
word_ready  output  1  controller can accept a word this cycle.
We  output  1  instruction-memory byte write enable, to the CPU.
write_address  output  32  byte address for the write, to the CPU.
write_data  output  8  byte to write, to the CPU.
pc_enable  output  1  CPU run enable.
pipe_flush  output  1  high while loading; the top level uses it to squash pipeline registers.
busy  output  1  high in any state except IDLE and RUN.
done  output  1  one-cycle pulse when the load completes.
error  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst=1 at a clock edge): state becomes IDLE on that edge. All outputs are 0 and the word counter is cleared. Reset overrides every other input, including mid-load, and leaves no partial-write continuation.
- States are IDLE, WAIT_WORD, WRITE, DRAIN and RUN.
- IDLE: outputs 0. start with 1 <= num_words <= MAX_WORDS latches the length, clears word_idx and goes to WAIT_WORD. start with num_words=0 or num_words>MAX_WORDS pulses error for one cycle and stays IDLE.
- WAIT_WORD: word_ready=1, busy=1, pipe_flush=1, We=0. A word is accepted when word_valid&word_ready. The word is latched, byte_idx is cleared and the state goes to WRITE.
- WRITE: 4 cycles, byte_idx = 0..3. In each cycle:
  - We=1.
  - write_address = BASE_ADDR + 4*word_idx + byte_idx, in 32-bit modular arithmetic.
  - write_data is big-endian: byte 0 = word[31:24], byte 3 = word[7:0].
  - word_ready=0.
- After byte 3: word_idx increments. If word_idx+1 == length, go to DRAIN; otherwise go to WAIT_WORD.
- Throughput is at most one word per 5 cycles. The first byte write appears on the cycle after acceptance.
- DRAIN: 1 cycle with We=0, pc_enable=0, pipe_flush=1. Guarantees the last write has settled before fetch starts.
- RUN: pc_enable=1, pipe_flush=0, busy=0. done pulses for exactly the first RUN cycle. RUN persists until reset or start.
- Reload: start in RUN is handled as in IDLE. A valid start drops pc_enable on the next edge and enters WAIT_WORD. An invalid start pulses error and the controller remains in RUN.
- start while busy is ignored (no error, no restart).
- abort while busy returns to IDLE on the next edge:
  - An in-flight WRITE stops immediately.
  - done is not pulsed and pc_enable stays 0.
  - Bytes already written remain in memory.
  - abort in IDLE or RUN has no effect.
- Invariant: We and pc_enable are never 1 in the same cycle.
- Invariant: write_address and write_data are 0 whenever We=0.
- word_valid may remain high across cycles. Words presented outside WAIT_WORD are not consumed.
- If the address exceeds the instruction memory range, it wraps in memory. The controller does not check range.

Test Plan:
- Load 1 word: start, num_words=1, word 32'h2010_0005 → bytes 20,10,00,05 written to addresses 0..3 on consecutive cycles, one DRAIN cycle, then pc_enable=1 and done pulsed once.
- Load 3 words with word_valid always high → writes at addresses 0..11. word_ready is high for exactly 3 cycles, spaced 5 cycles apart. done occurs 16 cycles after the first acceptance.
- Zero-length and oversize starts: num_words=0, then num_words=257 → one error pulse each, state stays IDLE, We never asserted.
- Abort on the 2nd byte of word 1 (num_words=4) → We=0 on the next cycle, IDLE, no done, pc_enable=0. A subsequent start reloads from BASE_ADDR.
- Reset mid-WRITE → all outputs 0 on the next cycle. start after reset behaves identically to first boot.
- Reload from RUN, with start and num_words=2 → pc_enable falls the next cycle. Assertion checks across all tests that We&pc_enable is never 1. A second done pulse follows the reload.
